// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF = 32'd4;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect/stall controls, instruction ROM port and IF/ID triple.
interface fetch_if;
  logic stall;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic IF_valid;
  modport master (
    input stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, IF_pc, IF_inst, IF_valid
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input imem_addr, IF_pc, IF_inst, IF_valid
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, sequential increment and redirect-aware ROM address.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP = PC_STEP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  logic redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr
);
  logic [31:0] pc_q, pc_d;
  always_comb begin
    imem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
    pc_d = adv ? imem_addr + PC_STEP : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage producing the aligned {IF_pc, IF_inst, IF_valid} triple.
// Optional FETCH_PERF_CNT_EN adds saturating stall/redirect event counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP = PC_STEP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  fetch_if.master f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);
  state_e state_q, state_d;
  logic [31:0] rsp_pc_q, rsp_pc_d, inst_hold_q, inst_hold_d;
  logic rsp_valid_q, rsp_valid_d, adv;
  fetch_pc_gen #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_gen (
    .clk(clk),
    .rst_n(rst_n),
    .adv(adv),
    .redirect_valid(f.redirect_valid),
    .redirect_pc(f.redirect_pc),
    .imem_addr(f.imem_addr)
  );
  // Every non-frozen edge fetches whatever address is on imem_addr this cycle.
  always_comb begin
    adv = state_q == BOOT || f.redirect_valid || !f.stall;
    state_d = adv ? RUN : HOLD;
    rsp_pc_d = adv ? f.imem_addr : rsp_pc_q;
    rsp_valid_d = adv || rsp_valid_q;
    inst_hold_d = (state_q == RUN && !adv) ? (rsp_valid_q ? f.imem_rdata : NOP_INST) : inst_hold_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      rsp_pc_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      inst_hold_q <= NOP_INST;
    end else begin
      state_q <= state_d;
      rsp_pc_q <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
      inst_hold_q <= inst_hold_d;
    end
  end
  assign f.IF_pc = rsp_pc_q;
  assign f.IF_valid = rsp_valid_q;
  assign f.IF_inst = !rsp_valid_q ? NOP_INST : state_q == HOLD ? inst_hold_q : f.imem_rdata;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, redir_cnt_q, redir_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, f.stall && !f.redirect_valid && state_q != BOOT && stall_cnt_q != '1};
    redir_cnt_d = redir_cnt_q + {31'd0, f.redirect_valid && redir_cnt_q != '1};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0;
      redir_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan sequence plus randomized stall/redirect traffic
// checked against a behavioural fetch model and the rule IF_inst == ROM[IF_pc].
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_if bus();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_redirect_cnt;
`endif
  fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .f(bus.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h0 ? 32'h0000_0013 : a == 32'h4 ? 32'h0010_0093 : a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction
  always @(posedge clk) bus.imem_rdata <= rom(bus.imem_addr);

  int passed = 0;
  int total = 0;
  bit booted;
  logic m_valid;
  logic [31:0] m_pc, m_fetch, m_scnt, m_rcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    booted = 0;
    m_valid = 1'b0;
    m_pc = 32'h0;
    m_fetch = 32'h0;
    m_scnt = 32'h0;
    m_rcnt = 32'h0;
  endtask

  // Called at a negedge: apply inputs, check the cycle, advance the model over the edge.
  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    bus.stall = s;
    bus.redirect_valid = r;
    bus.redirect_pc = t;
    #1;
    chk("imem_addr", bus.imem_addr, r ? (t & ~32'h3) : m_fetch);
    chk("IF_valid", 32'(bus.IF_valid), 32'(m_valid));
    chk("IF_pc", bus.IF_pc, m_pc);
    chk("IF_inst", bus.IF_inst, m_valid ? rom(m_pc) : 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_scnt);
    chk("perf_redir", perf_redirect_cnt, m_rcnt);
`endif
    @(posedge clk);
    if (r) m_rcnt++;
    else if (s && booted) m_scnt++;
    if (r || !s || !booted) begin
      m_pc = r ? (t & ~32'h3) : m_fetch;
      m_fetch = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    booted = 1;
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.IF_valid), 32'h0);
    chk("rst_pc", bus.IF_pc, 32'h0);
    chk("rst_inst", bus.IF_inst, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
    chk("rst_perf_redir", perf_redirect_cnt, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    #1 chk("tp_stall_pc", bus.IF_pc, 32'h8);
    repeat (3) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    #1 chk("tp_after_stall", bus.IF_pc, 32'hC);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h103);
    #1 chk("tp_redir_pc", bus.IF_pc, 32'h100);
    cyc(1'b0, 1'b0, 32'h0);
    repeat (2) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h202);
    #1 chk("tp_hold_redir", bus.IF_pc, 32'h200);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    #1 chk("tp_wrap", bus.IF_pc, 32'h0);
    repeat (2) cyc(1'b1, 1'b0, 32'h0);
    bus.stall = 1'b1;
    async_reset();
    cyc(1'b0, 1'b0, 32'h0);
    #1 chk("tp_restart", bus.IF_pc, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) async_reset();
      else cyc($urandom_range(9) < 3, $urandom_range(9) == 0, $urandom);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC pipeline, i.e. the producer side of the IF/ID pipeline register.
- Owns the fetch PC and drives a synchronous instruction ROM (1-cycle read latency).
- Presents an aligned {IF_pc, IF_inst, IF_valid} triple to IF/ID.
- Holds that triple stable under downstream stall and retargets on branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold request from hazard unit; IF outputs must not change while high.
- redirect_valid  in  1  branch/jump taken; redirect_pc becomes the next fetch address.
- redirect_pc  in  32  redirect target.
- imem_addr  out  32  ROM address; combinational.
- imem_rdata  in  32  ROM data for the address presented on the previous cycle.
- IF_pc  out  32  PC of the presented instruction.
- IF_inst  out  32  presented instruction; 32'h0 when not valid.
- IF_valid  out  1  presented instruction is real (not a bubble).

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n), and is the only reset.
- State register: 2-bit FSM {BOOT, RUN, HOLD}.
  - pc_q: next fetch address.
  - rsp_pc_q: PC whose data is on imem_rdata.
  - rsp_valid_q.
  - inst_hold_q: 32-bit hold buffer.
- Reset values: state=BOOT, pc_q=RESET_PC, rsp_pc_q=0, rsp_valid_q=0, inst_hold_q=0.
  - Outputs during reset and BOOT: IF_pc=0, IF_inst=0, IF_valid=0.
- imem_addr:
  - redirect_valid=1: {redirect_pc[31:2],2'b00}.
  - Otherwise: pc_q.
  - redirect_pc[1:0] are ignored everywhere.
- Output mux:
  - IF_pc = rsp_pc_q.
  - IF_valid = rsp_valid_q.
  - IF_inst = 0 if !rsp_valid_q; inst_hold_q if state=HOLD; else imem_rdata.
- Transition priority: redirect > stall > advance. The rules below apply at each posedge.
- BOOT: stall is ignored. Go to RUN, with rsp_pc_q=imem_addr, rsp_valid_q=1, pc_q=imem_addr+PC_STEP.
  - First valid instruction therefore appears 1 cycle after reset release.
- RUN, redirect_valid: rsp_pc_q=target, rsp_valid_q=1, pc_q=target+PC_STEP; stay in RUN.
  - Zero fetch penalty in this block. The wrong-path instruction shown during the redirect cycle is squashed downstream.
- RUN, stall (no redirect):
  - inst_hold_q = rsp_valid_q ? imem_rdata : 0; go to HOLD.
  - pc_q and rsp_* are unchanged.
- RUN, neither: rsp_pc_q=pc_q, rsp_valid_q=1, pc_q=pc_q+PC_STEP.
- HOLD, stall still high: all state frozen; outputs identical to the cycle stall was first sampled.
- HOLD, stall low: outputs still show inst_hold_q for this one cycle. At the edge, advance as RUN/neither and go to RUN.
  - The ROM has been reading pc_q throughout, so the next rdata is correct.
- HOLD, redirect_valid (with or without stall): treat as RUN/redirect; go to RUN.
- Arithmetic: all PC adds are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0.
- rst_n asserted mid-stall or mid-redirect: immediate return to reset values; hold buffer content is discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds two outputs, perf_stall_cnt[31:0] and perf_redirect_cnt[31:0].
  - perf_stall_cnt increments on each cycle where stall=1, redirect_valid=0 and state!=BOOT.
  - perf_redirect_cnt increments on each cycle where redirect_valid=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg holds:
  - the FSM state enum (BOOT/RUN/HOLD);
  - NOP_INST = 32'h0;
  - default RESET_PC;
  - PC_STEP.
- One natural sub-module, fetch_pc_gen. It contains the pc_q register, the +PC_STEP adder, the redirect alignment and the imem_addr mux.
- The FSM, response registers and hold buffer stay in fetch_unit.

Test Plan:
- Reset release, ROM[0]=0x0000_0013, ROM[4]=0x0010_0093:
  - cycle 0 after release: IF_valid=0, IF_inst=0;
  - cycle 1: IF_pc=0x0, IF_inst=0x0000_0013;
  - cycle 2: IF_pc=0x4, IF_inst=0x0010_0093.
- Stall for 3 cycles while IF_pc=0x8:
  - IF_pc=0x8 and IF_inst=ROM[8] are held for 4 cycles total;
  - the cycle after the stall drops shows IF_pc=0xC with ROM[0xC];
  - imem_addr=0xC throughout the stall.
- redirect_valid with redirect_pc=0x103 while IF_pc=0x10: imem_addr=0x100 that cycle; next cycle IF_pc=0x100, IF_inst=ROM[0x100], then IF_pc=0x104.
- redirect_valid=1 and stall=1 together while in HOLD: redirect wins; next cycle IF_pc=target, state RUN, hold buffer unused.
- pc_q=0xFFFF_FFFC: after IF_pc=0xFFFF_FFFC, the next IF_pc=0x0000_0000.
- rst_n pulsed low mid-HOLD: outputs go to 0 asynchronously; fetch restarts at RESET_PC with one bubble cycle.
  - With FETCH_PERF_CNT_EN: both counters read 0.
